// File: rtl/afifo_rd_pkg.sv
// Shared types for the async-FIFO read-side drainer.
// The entry layout {last, data} is the packing used by the output buffer.
package afifo_rd_pkg;

    localparam int RD_DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic                 last;
        logic [RD_DATA_W-1:0] data;
    } rd_entry_t;

endpackage

// File: rtl/afifo_rd_skid.sv
// Two-entry output buffer of {last, data}. The head register drives the output
// directly, so the output data is registered and holds steady while stalled.
module afifo_rd_skid #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH:0]   entry_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH:0]   entry_o,
    output logic [1:0]            occ_o
);

    logic [1:0]          occ_q, occ_d;
    logic [DATA_WIDTH:0] head_q, head_d;
    logic [DATA_WIDTH:0] tail_q, tail_d;
    logic                pop;

    assign pop = (occ_q != 2'd0) && ready_i;

    // The producer never pushes while full, so a push at occ=2 is ignored.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            2'd0: begin
                if (push_i) begin
                    head_d = entry_i;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && pop) begin
                    head_d = entry_i;
                end else if (push_i) begin
                    tail_d = entry_i;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d  = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign valid_o = (occ_q != 2'd0);
    assign entry_o = head_q;
    assign occ_o   = occ_q;

endmodule

// File: rtl/afifo_rd_drainer.sv
// Read-side consumer of the async FIFO: pops first-word-fall-through words and
// re-emits them as fixed-length bursts with an end-of-burst marker.
module afifo_rd_drainer
    import afifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  en,
    input  logic [LEN_W-1:0]      burst_len,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_W-1:0]      pop_count
);

    rd_state_e           state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]    pop_count_q;
    logic [1:0]          occ;
    logic                push_last;
    logic                rinc_int;
    logic [DATA_WIDTH:0] head_entry;

    assign rinc_int  = (state_q == BURST) && !rempty && (occ < 2'd2);
    assign push_last = (beat_q == len_q - LEN_W'(1));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (en && !rempty) begin
                    state_d = BURST;
                    // A zero length would never terminate; treat it as one word.
                    len_d   = (burst_len == '0) ? LEN_W'(1) : burst_len;
                    beat_d  = '0;
                end
            end
            default: begin
                if (rinc_int) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (push_last) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            beat_q      <= '0;
            pop_count_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            if (rinc_int && (pop_count_q != {CNT_W{1'b1}})) begin
                pop_count_q <= pop_count_q + CNT_W'(1);
            end
        end
    end

    afifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (rclk),
        .srst    (rrst),
        .push_i  (rinc_int),
        .entry_i ({push_last, rdata}),
        .valid_o (m_valid),
        .ready_i (m_ready),
        .entry_o (head_entry),
        .occ_o   (occ)
    );

    assign rinc      = rinc_int;
    assign m_last    = head_entry[DATA_WIDTH];
    assign m_data    = head_entry[DATA_WIDTH-1:0];
    assign busy      = (state_q == BURST) || (occ != 2'd0);
    assign pop_count = pop_count_q;

endmodule

// File: tb/tb_afifo_rd_drainer.sv
// Randomised bench for afifo_rd_drainer against a transaction-level model:
// a FIFO queue feeding the DUT and a queue of words expected on the output.
module tb_afifo_rd_drainer;

    localparam int DW = 32;
    localparam int LW = 8;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          en = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          rempty = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic          m_ready = 1'b0;
    logic          rinc, m_valid, m_last, busy;
    logic [DW-1:0] m_data;
    logic [CW-1:0] pop_count;

    always #5 rclk = ~rclk;

    afifo_rd_drainer #(
        .DATA_WIDTH (DW),
        .LEN_W      (LW),
        .CNT_W      (CW)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .en        (en),
        .burst_len (burst_len),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .busy      (busy),
        .pop_count (pop_count)
    );

    typedef struct {
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0] fifo_q[$];
    exp_t          exp_q[$];
    bit            in_burst;
    int            len_m, cnt_m, total_pops, seq, cyc;
    int            n_checks, n_fail;

    task automatic chk(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive_fifo();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? '0 : fifo_q[0];
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            seq++;
            fifo_q.push_back({16'(seq), 16'($urandom)});
        end
        drive_fifo();
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit            exp_rinc, exp_valid, accept, start, obs_rinc;
        int            sat, len_s;
        logic [DW-1:0] head;
        exp_t          e;
        @(negedge rclk);
        exp_rinc  = in_burst && (fifo_q.size() != 0) && (exp_q.size() < 2);
        exp_valid = (exp_q.size() != 0);
        sat       = (total_pops > SAT) ? SAT : total_pops;
        chk("rinc", (DW+1)'(rinc), (DW+1)'(exp_rinc));
        chk("m_valid", (DW+1)'(m_valid), (DW+1)'(exp_valid));
        chk("busy", (DW+1)'(busy), (DW+1)'(in_burst || exp_valid));
        chk("pop_count", (DW+1)'(pop_count), (DW+1)'(sat));
        if (exp_valid) begin
            chk("m_data", (DW+1)'(m_data), (DW+1)'(exp_q[0].data));
            chk("m_last", (DW+1)'(m_last), (DW+1)'(exp_q[0].last));
        end
        accept   = exp_valid && m_ready;
        start    = !in_burst && en && (fifo_q.size() != 0);
        len_s    = (burst_len == '0) ? 1 : int'(burst_len);
        obs_rinc = rinc;
        head     = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        @(posedge rclk);
        cyc++;
        if (accept) void'(exp_q.pop_front());
        if (exp_rinc) begin
            cnt_m++;
            e.data = head;
            e.last = (cnt_m == len_m);
            exp_q.push_back(e);
            total_pops++;
            if (e.last) in_burst = 0;
        end else if (start) begin
            in_burst = 1;
            len_m    = len_s;
            cnt_m    = 0;
        end
        if (obs_rinc && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (rrst) begin
            in_burst   = 0;
            exp_q.delete();
            total_pops = 0;
            cnt_m      = 0;
        end
        #1;
        drive_fifo();
    endtask

    // Drain with en=1, m_ready=1; tops up the FIFO if a burst is waiting for words.
    task automatic run_idle(input int maxc);
        int c = 0;
        en      = 1'b1;
        m_ready = 1'b1;
        while ((in_burst || exp_q.size() != 0 || fifo_q.size() != 0) && c < maxc) begin
            if (in_burst && fifo_q.size() == 0) push_words(1);
            cycle();
            c++;
        end
        chk("drained", (DW+1)'(in_burst || exp_q.size() != 0 || fifo_q.size() != 0), '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 3 cycles with a word waiting and en high.
        rrst = 1'b1; en = 1'b1; burst_len = LW'(1); m_ready = 1'b1;
        push_words(1);
        @(posedge rclk); #1;
        repeat (3) cycle();
        chk("rst_m_data", (DW+1)'(m_data), '0);
        chk("rst_m_last", (DW+1)'(m_last), '0);
        rrst = 1'b0;
        run_idle(50);

        // Single burst of 4.
        en = 1'b0; burst_len = LW'(4);
        push_words(4);
        run_idle(50);

        // Three back-to-back bursts of 2.
        en = 1'b0; burst_len = LW'(2);
        push_words(6);
        run_idle(50);

        // Backpressure: burst of 8 with m_ready low for several cycles.
        en = 1'b1; m_ready = 1'b0; burst_len = LW'(8);
        push_words(8);
        repeat (7) cycle();
        run_idle(50);

        // FIFO runs dry mid-burst and en drops; burst must still complete.
        en = 1'b1; m_ready = 1'b1; burst_len = LW'(3);
        push_words(1);
        repeat (3) cycle();
        en = 1'b0;
        repeat (4) cycle();
        push_words(2);
        repeat (6) cycle();

        // burst_len=0 behaves as single-word bursts.
        burst_len = '0;
        push_words(5);
        run_idle(50);
        chk("pop_sat", (DW+1)'(pop_count), (DW+1)'(SAT));

        // Reset with the buffer full, then finish the interrupted data.
        en = 1'b1; m_ready = 1'b0; burst_len = LW'(8);
        push_words(8);
        repeat (6) cycle();
        rrst = 1'b1;
        cycle();
        rrst = 1'b0;
        chk("midrst_m_valid", (DW+1)'(m_valid), '0);
        chk("midrst_pop_count", (DW+1)'(pop_count), '0);
        chk("midrst_m_data", (DW+1)'(m_data), '0);
        run_idle(80);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            burst_len = LW'($urandom_range(0, 5));
            en        = ($urandom_range(0, 3) != 0);
            m_ready   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) push_words(1);
            cycle();
        end
        run_idle(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
